// File: rtl/video_pkg.sv
// Shared video-side definitions: sprite RAM geometry and the sprite RAM arbiter state encoding.
// Imported by the sprite RAM arbiter.
package video_pkg;

  localparam int VIDEO_AW   = 13;
  localparam int RD_LAT_MAX = 3;

  localparam logic [VIDEO_AW-1:0] SPRITE_RAM_BASE  = 13'h0000;
  localparam logic [VIDEO_AW-1:0] SPRITE_ATTR_BASE = 13'h1800;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU_WR = 2'd1,
    ST_CPU_RD = 2'd2,
    ST_DMA_RD = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } grant_t;

endpackage

// File: rtl/sprite_ram_dma_arbiter.sv
// Single-port sprite RAM arbiter: round-robin between CPU and video DMA, one access in flight.
// Access = grant cycle + RD_LAT cycles (writes: grant + 1); the losing side is held off by cpu_wait/dma_wait.
module sprite_ram_dma_arbiter
  import video_pkg::*;
#(
  parameter int AW     = VIDEO_AW,
  parameter int RD_LAT = 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  output logic          cpu_wait,
  input  logic          dma_en,
  input  logic [AW-1:0] dma_addr,
  output logic [7:0]    dma_data,
  output logic          dma_wait,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);

  localparam logic [RD_LAT_MAX-1:0] LAT_INIT = RD_LAT_MAX'(1) << (RD_LAT - 1);

  arb_state_t            state_q, state_d;
  grant_t                last_grant_q, last_grant_d;
  logic                  cpu_done_q, cpu_done_d;
  logic                  tag_vld_q, tag_vld_d;
  logic [AW-1:0]         dma_tag_q, dma_tag_d;
  logic [AW-1:0]         acc_addr_q, acc_addr_d;
  logic [7:0]            cpu_din_q, cpu_din_d;
  logic [7:0]            dma_data_q, dma_data_d;
  logic [RD_LAT_MAX-1:0] lat_q, lat_d;

  logic cpu_pend;
  logic dma_pend;
  logic gnt_cpu;
  logic gnt_dma;
  logic lat_done;

  assign cpu_pend = cpu_cs & ~cpu_done_q;
  assign dma_wait = dma_en & ~(tag_vld_q & (dma_tag_q == dma_addr));
  assign dma_pend = dma_wait;
  assign cpu_wait = cpu_pend & ~reset;
  assign lat_done = lat_q[0];

  // Grants are issued only from IDLE; the grant cycle itself presents the address to the RAM.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dma = 1'b0;
    if ((state_q == ST_IDLE) && !reset) begin
      if (cpu_pend && dma_pend) begin
        gnt_cpu = (last_grant_q == GNT_DMA);
        gnt_dma = (last_grant_q == GNT_CPU);
      end else begin
        gnt_cpu = cpu_pend;
        gnt_dma = dma_pend;
      end
    end
  end

  always_comb begin
    ram_addr  = acc_addr_q;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (gnt_cpu) begin
      ram_addr = cpu_addr;
      if (cpu_we) begin
        ram_we    = 1'b1;
        ram_wdata = cpu_dout;
      end
    end else if (gnt_dma) begin
      ram_addr = dma_addr;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cpu_done_d   = cpu_done_q & cpu_cs;
    tag_vld_d    = tag_vld_q;
    dma_tag_d    = dma_tag_q;
    acc_addr_d   = acc_addr_q;
    cpu_din_d    = cpu_din_q;
    dma_data_d   = dma_data_q;
    lat_d        = lat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_cpu) begin
          last_grant_d = GNT_CPU;
          acc_addr_d   = cpu_addr;
          lat_d        = LAT_INIT;
          state_d      = cpu_we ? ST_CPU_WR : ST_CPU_RD;
          // A write under the cached DMA byte invalidates it so the video side refetches.
          if (cpu_we && (cpu_addr == dma_tag_q)) begin
            tag_vld_d = 1'b0;
          end
        end else if (gnt_dma) begin
          last_grant_d = GNT_DMA;
          acc_addr_d   = dma_addr;
          lat_d        = LAT_INIT;
          state_d      = ST_DMA_RD;
        end
      end

      ST_CPU_WR: begin
        cpu_done_d = cpu_cs;
        state_d    = ST_IDLE;
      end

      ST_CPU_RD: begin
        lat_d = lat_q >> 1;
        if (lat_done) begin
          state_d    = ST_IDLE;
          cpu_done_d = cpu_cs;
          if (cpu_cs) begin
            cpu_din_d = ram_rdata;
          end
        end
      end

      ST_DMA_RD: begin
        lat_d = lat_q >> 1;
        if (lat_done) begin
          state_d    = ST_IDLE;
          dma_data_d = ram_rdata;
          dma_tag_d  = acc_addr_q;
          tag_vld_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_DMA;
      cpu_done_q   <= 1'b0;
      tag_vld_q    <= 1'b0;
      dma_tag_q    <= '0;
      acc_addr_q   <= '0;
      cpu_din_q    <= 8'h00;
      dma_data_q   <= 8'h00;
      lat_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cpu_done_q   <= cpu_done_d;
      tag_vld_q    <= tag_vld_d;
      dma_tag_q    <= dma_tag_d;
      acc_addr_q   <= acc_addr_d;
      cpu_din_q    <= cpu_din_d;
      dma_data_q   <= dma_data_d;
      lat_q        <= lat_d;
    end
  end

  assign cpu_din  = cpu_din_q;
  assign dma_data = dma_data_q;

endmodule

// File: tb/tb_sprite_ram_dma_arbiter.sv
// Directed bench for sprite_ram_dma_arbiter: RD_LAT=1 instance for most scenarios,
// RD_LAT=3 instance for long-latency and mid-access reset.
module tb_sprite_ram_dma_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        mem_init;
  logic        cpu_cs, cpu3_cs, cpu_we, dma_en, dma3_en;
  logic [12:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_dout;

  logic [7:0]  cpu_din, dma_data, ram_wdata, ram_rdata;
  logic        cpu_wait, dma_wait, ram_we;
  logic [12:0] ram_addr;

  logic [7:0]  c3_din, c3_data, ram3_wdata, ram3_rdata;
  logic        c3_wait, dma3_wait, ram3_we;
  logic [12:0] ram3_addr;

  logic [7:0]  mem1 [0:8191];
  logic [7:0]  mem3 [0:8191];
  logic [7:0]  rd3_p [0:2];
  int          we1_cnt = 0;
  int          we3_cnt = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] img(input int a);
    logic [31:0] v;
    if (a == 32'h17FC) return 8'h3C;
    v = (a * 37) ^ (a >> 5);
    return v[7:0];
  endfunction

  sprite_ram_dma_arbiter #(.AW(13), .RD_LAT(1)) u_dut (
    .clk_sys(clk_sys), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_wait(cpu_wait),
    .dma_en(dma_en), .dma_addr(dma_addr), .dma_data(dma_data), .dma_wait(dma_wait),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  sprite_ram_dma_arbiter #(.AW(13), .RD_LAT(3)) u_dut3 (
    .clk_sys(clk_sys), .reset(reset),
    .cpu_cs(cpu3_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_din(c3_din), .cpu_wait(c3_wait),
    .dma_en(dma3_en), .dma_addr(dma_addr), .dma_data(c3_data), .dma_wait(dma3_wait),
    .ram_addr(ram3_addr), .ram_we(ram3_we), .ram_wdata(ram3_wdata), .ram_rdata(ram3_rdata)
  );

  // RAM models: 1-cycle and 3-cycle registered reads.
  always @(posedge clk_sys) begin
    if (mem_init) begin
      for (int i = 0; i < 8192; i++) begin
        mem1[i] <= img(i);
        mem3[i] <= img(i);
      end
    end else begin
      if (ram_we)  mem1[ram_addr]  <= ram_wdata;
      if (ram3_we) mem3[ram3_addr] <= ram3_wdata;
    end
    ram_rdata <= mem1[ram_addr];
    rd3_p[0]  <= mem3[ram3_addr];
    rd3_p[1]  <= rd3_p[0];
    rd3_p[2]  <= rd3_p[1];
    if (ram_we)  we1_cnt <= we1_cnt + 1;
    if (ram3_we) we3_cnt <= we3_cnt + 1;
  end
  assign ram3_rdata = rd3_p[2];

  task automatic wait_dma(output int cyc);
    cyc = 0;
    while (dma_wait && cyc < 16) begin @(negedge clk_sys); #1; cyc++; end
  endtask

  task automatic wait_cpu(output int cyc);
    cyc = 0;
    while (cpu_wait && cyc < 16) begin @(negedge clk_sys); #1; cyc++; end
  endtask

  task automatic wait_cpu3(output int cyc);
    cyc = 0;
    while (c3_wait && cyc < 16) begin @(negedge clk_sys); #1; cyc++; end
  endtask

  task automatic test_reset;
    logic [45:0] outs;
    reset = 1'b1; mem_init = 1'b1;
    cpu_cs = 1'b0; cpu3_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_dout = '0;
    dma_en = 1'b0; dma3_en = 1'b0; dma_addr = '0;
    repeat (3) @(negedge clk_sys);
    mem_init = 1'b0;
    #1;
    outs = {cpu_din, cpu_wait, dma_data, ram_addr, ram_we, ram_wdata, dma_wait, 6'd0};
    total++;
    if (outs !== 46'd0) begin
      bad++; $display("FAIL rst_outputs got=%h expected=0", outs);
    end
    outs = {c3_din, c3_wait, c3_data, ram3_addr, ram3_we, ram3_wdata, dma3_wait, 6'd0};
    total++;
    if (outs !== 46'd0) begin
      bad++; $display("FAIL rst_outputs_lat3 got=%h expected=0", outs);
    end
    dma_en = 1'b1; #1;
    total++;
    if (dma_wait !== 1'b1) begin
      bad++; $display("FAIL rst_dma_wait_no_tag got=%b expected=1", dma_wait);
    end
    dma_en = 1'b0;
    @(negedge clk_sys); reset = 1'b0;
    @(negedge clk_sys); #1;
    total++;
    if ({cpu_wait, dma_wait, ram_we, ram_addr} !== 16'd0) begin
      bad++; $display("FAIL rst_idle_after_release got=%h expected=0", {cpu_wait, dma_wait, ram_we, ram_addr});
    end
  endtask

  task automatic test_dma_sweep;
    int cyc;
    int errs;
    errs = 0;
    dma_en = 1'b1;
    for (int a = 0; a < 8192; a++) begin
      dma_addr = 13'(a);
      #1;
      wait_dma(cyc);
      total++;
      if (dma_wait !== 1'b0 || dma_data !== img(a)) begin
        bad++; errs++;
        if (errs <= 20)
          $display("FAIL t1_dma_data addr=%h got=%h expected=%h wait=%b", a, dma_data, img(a), dma_wait);
      end
    end
    dma_en = 1'b0;
  endtask

  task automatic test_cpu_write_hold;
    int base;
    int low_at;
    bit relapse;
    @(negedge clk_sys);
    base = we1_cnt;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1500; cpu_dout = 8'hA5;
    #1;
    total++;
    if ({cpu_wait, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 13'h1500, 8'hA5}) begin
      bad++; $display("FAIL t2_grant_cycle got=%h expected=%h", {cpu_wait, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 13'h1500, 8'hA5});
    end
    low_at = -1; relapse = 1'b0;
    for (int c = 1; c < 6; c++) begin
      @(negedge clk_sys); #1;
      if (!cpu_wait && low_at < 0) low_at = c;
      if (cpu_wait && low_at >= 0) relapse = 1'b1;
    end
    total++;
    if (low_at != 2 || relapse) begin
      bad++; $display("FAIL t2_wait_low_cycle got=%0d relapse=%b expected=2", low_at, relapse);
    end
    cpu_cs = 1'b0; cpu_we = 1'b0;
    @(negedge clk_sys); #1;
    total++;
    if (we1_cnt - base != 1) begin
      bad++; $display("FAIL t2_we_pulses got=%0d expected=1", we1_cnt - base);
    end
  endtask

  task automatic test_contention;
    @(negedge clk_sys);
    dma_en = 1'b1; dma_addr = 13'h0100;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h17FC;
    #1;
    total++;
    if (ram_addr !== 13'h0100 || ram_we !== 1'b0) begin
      bad++; $display("FAIL t3_dma_first got=%h expected=0100", ram_addr);
    end
    @(negedge clk_sys);
    @(negedge clk_sys); #1;
    total++;
    if ({dma_wait, cpu_wait, dma_data} !== {1'b0, 1'b1, img(32'h100)}) begin
      bad++; $display("FAIL t3_dma_done got=%b%b %h expected=01 %h", dma_wait, cpu_wait, dma_data, img(32'h100));
    end
    dma_addr = 13'h0101; #1;
    total++;
    if (ram_addr !== 13'h17FC) begin
      bad++; $display("FAIL t3_cpu_granted got=%h expected=17fc", ram_addr);
    end
    @(negedge clk_sys);
    @(negedge clk_sys); #1;
    total++;
    if (cpu_wait !== 1'b0 || cpu_din !== 8'h3C) begin
      bad++; $display("FAIL t3_cpu_read got=%h wait=%b expected=3c", cpu_din, cpu_wait);
    end
    total++;
    if (ram_addr !== 13'h0101) begin
      bad++; $display("FAIL t3_dma_granted got=%h expected=0101", ram_addr);
    end
    cpu_cs = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys); #1;
    total++;
    if (dma_wait !== 1'b0 || dma_data !== img(32'h101)) begin
      bad++; $display("FAIL t3_dma_second got=%h wait=%b expected=%h", dma_data, dma_wait, img(32'h101));
    end
  endtask

  task automatic test_tag_invalidate;
    int cyc;
    dma_addr = 13'h1980; #1;
    wait_dma(cyc);
    total++;
    if (dma_wait !== 1'b0 || dma_data !== img(32'h1980)) begin
      bad++; $display("FAIL t4_tag_valid got=%h wait=%b expected=%h", dma_data, dma_wait, img(32'h1980));
    end
    @(negedge clk_sys);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1980; cpu_dout = 8'hFF;
    #1;
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 13'h1980) begin
      bad++; $display("FAIL t4_cpu_write got=we%b %h expected=we1 1980", ram_we, ram_addr);
    end
    @(negedge clk_sys); #1;
    total++;
    if (dma_wait !== 1'b1) begin
      bad++; $display("FAIL t4_wait_rises got=%b expected=1", dma_wait);
    end
    wait_cpu(cyc);
    cpu_cs = 1'b0; cpu_we = 1'b0;
    wait_dma(cyc);
    total++;
    if (dma_wait !== 1'b0 || dma_data !== 8'hFF) begin
      bad++; $display("FAIL t4_refetch got=%h wait=%b expected=ff", dma_data, dma_wait);
    end
    dma_en = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    int cyc;
    int base3;
    logic [45:0] outs;
    @(negedge clk_sys);
    base3 = we3_cnt;
    cpu3_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0222; #1;
    wait_cpu3(cyc);
    total++;
    if (cyc != 4 || c3_wait !== 1'b0 || c3_din !== img(32'h222)) begin
      bad++; $display("FAIL t5_read_lat3 got=%h cycles=%0d expected=%h cycles=4", c3_din, cyc, img(32'h222));
    end
    cpu3_cs = 1'b0;
    @(negedge clk_sys);
    cpu3_cs = 1'b1; cpu_addr = 13'h0333;
    @(negedge clk_sys);
    @(negedge clk_sys); #1;
    reset = 1'b1; #1;
    outs = {c3_din, c3_wait, c3_data, ram3_addr, ram3_we, ram3_wdata, dma3_wait, 6'd0};
    total++;
    if (outs !== 46'd0) begin
      bad++; $display("FAIL t5_reset_outputs got=%h expected=0", outs);
    end
    cpu3_cs = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    repeat (3) @(negedge clk_sys); #1;
    total++;
    if (we3_cnt != base3 || c3_wait !== 1'b0 || c3_din !== 8'h00) begin
      bad++; $display("FAIL t5_quiet_after_reset got=we%0d din=%h expected=we0 din=00", we3_cnt - base3, c3_din);
    end
    cpu3_cs = 1'b1; #1;
    wait_cpu3(cyc);
    total++;
    if (cyc != 4 || c3_wait !== 1'b0 || c3_din !== img(32'h333)) begin
      bad++; $display("FAIL t5_fresh_read got=%h cycles=%0d expected=%h cycles=4", c3_din, cyc, img(32'h333));
    end
    cpu3_cs = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [12:0] addrs [3];
    logic [7:0]  exps  [3];
    int cyc;
    bit dw_seen;
    addrs[0] = 13'h1500; exps[0] = 8'hA5;
    addrs[1] = 13'h1980; exps[1] = 8'hFF;
    addrs[2] = 13'h1FFE; exps[2] = img(32'h1FFE);
    dma_en = 1'b0; dma_addr = 13'h0ABC;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = addrs[k]; #1;
      dw_seen = dma_wait;
      cyc = 0;
      while (cpu_wait && cyc < 16) begin
        @(negedge clk_sys); #1; cyc++;
        dw_seen = dw_seen | dma_wait;
      end
      total++;
      if (cyc != 2 || cpu_din !== exps[k] || dw_seen) begin
        bad++; $display("FAIL t6_read%0d got=%h cycles=%0d dma_wait_seen=%b expected=%h cycles=2", k, cpu_din, cyc, dw_seen, exps[k]);
      end
      cpu_cs = 1'b0;
    end
    total++;
    if (dma_data !== 8'h00) begin
      bad++; $display("FAIL t6_no_dma_fetch got=%h expected=00", dma_data);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_dma_sweep();
    test_cpu_write_hold();
    test_contention();
    test_tag_invalidate();
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
